// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - plays one of four fixed 8-note melodies as a square wave on the buzzer.
// Define MELODY_LOOP_EN to loop the song; by default it plays once and waits for a new start.
module melody_sequencer #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BEAT_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 1_250_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] song_sel,
  input  logic       play_en,
  output logic       buzzer,
  output logic [2:0] note_idx,
  output logic [2:0] pitch_code,
  output logic       playing,
  output logic       song_done
);

  localparam int HP1 = (CLK_FREQ / 524  > 0) ? CLK_FREQ / 524  : 1;
  localparam int HP2 = (CLK_FREQ / 588  > 0) ? CLK_FREQ / 588  : 1;
  localparam int HP3 = (CLK_FREQ / 660  > 0) ? CLK_FREQ / 660  : 1;
  localparam int HP4 = (CLK_FREQ / 698  > 0) ? CLK_FREQ / 698  : 1;
  localparam int HP5 = (CLK_FREQ / 784  > 0) ? CLK_FREQ / 784  : 1;
  localparam int HP6 = (CLK_FREQ / 880  > 0) ? CLK_FREQ / 880  : 1;
  localparam int HP7 = (CLK_FREQ / 1046 > 0) ? CLK_FREQ / 1046 : 1;

  // C4 has the longest half period, so it sizes the tone counter.
  localparam int TW = $clog2(HP1 + 1);
  localparam int BW = (BEAT_CYCLES > 2) ? $clog2(BEAT_CYCLES) : 1;

  localparam logic [BW-1:0] TONE_LAST = BW'(BEAT_CYCLES - GAP_CYCLES - 2);
  localparam logic [BW-1:0] GAP_LAST  = BW'(BEAT_CYCLES - 2);

  // Note 0 sits in the least significant 3 bits.
  localparam logic [23:0] SONG0 = {3'd7, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
  localparam logic [23:0] SONG1 = {3'd0, 3'd5, 3'd6, 3'd6, 3'd5, 3'd5, 3'd1, 3'd1};
  localparam logic [23:0] SONG2 = {3'd0, 3'd3, 3'd3, 3'd3, 3'd2, 3'd1, 3'd2, 3'd3};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_TONE, S_GAP} state_t;

  function automatic logic [2:0] rom_pitch(input logic [1:0] sel, input logic [2:0] idx);
    logic [23:0] song;
    case (sel)
      2'd0:    song = SONG0;
      2'd1:    song = SONG1;
      2'd2:    song = SONG2;
      default: song = '0;
    endcase
    return song[idx*3 +: 3];
  endfunction

  function automatic logic [TW-1:0] half_period(input logic [2:0] p);
    case (p)
      3'd1:    return TW'(HP1);
      3'd2:    return TW'(HP2);
      3'd3:    return TW'(HP3);
      3'd4:    return TW'(HP4);
      3'd5:    return TW'(HP5);
      3'd6:    return TW'(HP6);
      3'd7:    return TW'(HP7);
      default: return TW'(1);
    endcase
  endfunction

  state_t          r_state;
  logic [1:0]      r_sel_q;
  logic [2:0]      r_note_idx;
  logic [2:0]      r_pitch_code;
  logic            r_buzzer;
  logic [BW-1:0]   r_beat_cnt;
  logic [TW-1:0]   r_tone_cnt;
  logic            r_song_done;

  state_t          w_state_nx;
  logic [2:0]      w_note_nx;
  logic [2:0]      w_pitch_nx;
  logic            w_buzz_nx;
  logic [BW-1:0]   w_beat_nx;
  logic [TW-1:0]   w_tone_nx;
  logic            w_done_nx;
  logic            w_slot_end;
  logic            w_start;
  logic            w_sel_change;
  logic [TW-1:0]   w_hp_last;

  assign playing      = (r_state != S_IDLE);
  assign w_sel_change = playing && (song_sel != r_sel_q);
  assign w_hp_last    = half_period(r_pitch_code) - TW'(1);

`ifdef MELODY_LOOP_EN
  assign w_start = play_en;
`else
  // A finished one-shot song only restarts on a fresh play_en edge or a new selection.
  logic r_play_en_q;
  assign w_start = play_en && (!r_play_en_q || (song_sel != r_sel_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_play_en_q <= 1'b0;
    else        r_play_en_q <= play_en;
  end
`endif

  always_comb begin
    w_state_nx = r_state;
    w_note_nx  = r_note_idx;
    w_pitch_nx = r_pitch_code;
    w_buzz_nx  = r_buzzer;
    w_beat_nx  = r_beat_cnt;
    w_tone_nx  = r_tone_cnt;
    w_done_nx  = 1'b0;
    w_slot_end = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_buzz_nx = 1'b0;
        if (w_start) begin
          w_state_nx = S_LOAD;
          w_note_nx  = 3'd0;
        end
      end
      S_LOAD: begin
        w_beat_nx  = '0;
        w_tone_nx  = '0;
        w_buzz_nx  = 1'b0;
        w_state_nx = S_TONE;
      end
      S_TONE: begin
        w_beat_nx = r_beat_cnt + BW'(1);
        if (r_pitch_code == 3'd0) begin
          w_buzz_nx = 1'b0;
        end else if (r_tone_cnt == w_hp_last) begin
          w_buzz_nx = ~r_buzzer;
          w_tone_nx = '0;
        end else begin
          w_tone_nx = r_tone_cnt + TW'(1);
        end
        if (r_beat_cnt == TONE_LAST) begin
          if (GAP_CYCLES == 0) w_slot_end = 1'b1;
          else                 w_state_nx = S_GAP;
        end
      end
      S_GAP: begin
        w_beat_nx = r_beat_cnt + BW'(1);
        w_buzz_nx = 1'b0;
        if (r_beat_cnt == GAP_LAST) w_slot_end = 1'b1;
      end
      default: w_state_nx = S_IDLE;
    endcase

    if (w_slot_end) begin
      if (r_note_idx != 3'd7) begin
        w_note_nx  = r_note_idx + 3'd1;
        w_state_nx = S_LOAD;
      end else begin
        w_done_nx = 1'b1;
        w_note_nx = 3'd0;
`ifdef MELODY_LOOP_EN
        w_state_nx = S_LOAD;
`else
        w_state_nx = S_IDLE;
`endif
      end
    end

    if (w_sel_change) begin
      w_state_nx = S_LOAD;
      w_note_nx  = 3'd0;
    end

    if (!play_en) begin
      w_state_nx = S_IDLE;
      w_note_nx  = 3'd0;
      w_done_nx  = 1'b0;
    end

    // song_sel is what sel_q holds during the LOAD cycle, so the pitch is valid from LOAD on.
    if (w_state_nx == S_LOAD)      w_pitch_nx = rom_pitch(song_sel, w_note_nx);
    else if (w_state_nx == S_IDLE) w_pitch_nx = 3'd0;
    if (w_state_nx != S_TONE)      w_buzz_nx  = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_sel_q      <= 2'd0;
      r_note_idx   <= 3'd0;
      r_pitch_code <= 3'd0;
      r_buzzer     <= 1'b0;
      r_beat_cnt   <= '0;
      r_tone_cnt   <= '0;
      r_song_done  <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_sel_q      <= song_sel;
      r_note_idx   <= w_note_nx;
      r_pitch_code <= w_pitch_nx;
      r_buzzer     <= w_buzz_nx;
      r_beat_cnt   <= w_beat_nx;
      r_tone_cnt   <= w_tone_nx;
      r_song_done  <= w_done_nx;
    end
  end

  assign buzzer     = r_buzzer;
  assign note_idx   = r_note_idx;
  assign pitch_code = r_pitch_code;
  assign song_done  = r_song_done;

endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
- Consumer end of the song-select path: takes the 2-bit song index from the debounced button counter and plays that song.
- Plays the selected fixed 8-note melody as a square wave on the buzzer pin.
- Sequences notes from an internal ROM with a beat timer and a per-note tone divider.
- Restarts cleanly whenever the selection changes.

Parameters:
- CLK_FREQ, 50_000_000: clk frequency in Hz; sets the tone dividers.
- BEAT_CYCLES, 12_500_000: clk cycles per note slot (tone plus gap). Must be > GAP_CYCLES.
- GAP_CYCLES, 1_250_000: silent articulation cycles at the end of each slot. 0 means no gap.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- song_sel  input  2  song index; 0..2 from the button counter, 3 = silent song
- play_en  input  1  level; 1 = play, 0 = stop and go idle
- buzzer  output  1  square-wave tone output
- note_idx  output  3  index of the current note slot
- pitch_code  output  3  pitch code of the current note (0 = rest)
- playing  output  1  high in any state other than IDLE
- song_done  output  1  one-cycle pulse when note 7's slot completes

Behaviour:
- Reset values: all outputs 0, state IDLE, sel_q = 0.
- Pitch codes and frequencies:
  - 1 = C4 262 Hz, 2 = D4 294, 3 = E4 330, 4 = F4 349, 5 = G4 392, 6 = A4 440, 7 = C5 523 Hz.
  - Half-period HP = CLK_FREQ / (2 × freq), truncated, minimum 1.
- Songs (note 0..7; R = rest):
  - sel 0: 1 2 3 4 5 6 7 7
  - sel 1: 1 1 5 5 6 6 5 R
  - sel 2: 3 2 1 2 3 3 3 R
  - sel 3: all R
- song_sel handling:
  - Registered into sel_q every cycle.
  - sel_change = (song_sel != sel_q) while playing.
- States: IDLE, LOAD, TONE, GAP.
  - IDLE: buzzer 0. If play_en = 1, go to LOAD with note_idx = 0.
  - LOAD (1 cycle):
    - Latch pitch_code from ROM[sel_q][note_idx].
    - Clear the beat counter and tone counter; buzzer = 0.
    - Go to TONE.
  - TONE: lasts BEAT_CYCLES − GAP_CYCLES − 1 cycles (LOAD counts as the first cycle of the slot).
    - Tone counter counts 0..HP−1; buzzer toggles when the counter reaches HP−1, then the counter wraps to 0.
    - First rising edge of buzzer occurs HP cycles after TONE entry.
    - pitch_code 0: buzzer held 0.
    - Then go to GAP, or, if GAP_CYCLES = 0, end the slot.
  - GAP: buzzer 0 for GAP_CYCLES cycles, then end the slot.
  - End of slot:
    - If note_idx < 7: note_idx += 1, go to LOAD.
    - If note_idx = 7: song_done pulses for 1 cycle; wrap behaviour is set by the optional feature.
- Slot length is exactly BEAT_CYCLES cycles, measured LOAD to LOAD.
- Priority, highest first:
  1. play_en = 0: go to IDLE next cycle; note_idx = 0, pitch_code = 0, buzzer = 0. Allowed in any state.
  2. sel_change: go to LOAD next cycle with note_idx = 0, using the new sel_q.
  3. Normal sequencing.
- A sel_change in the same cycle as end of note 7 restarts the new song; song_done still pulses.
- Asynchronous reset mid-note: outputs go to 0 immediately; the block resumes from IDLE after release.
- Counter widths: sized by $clog2 of BEAT_CYCLES and of the largest HP.

Optional Feature:
- Macro: MELODY_LOOP_EN.
- Defined: after note 7, wrap to note_idx 0 and LOAD. The song loops while play_en = 1.
- Undefined (one-shot):
  - After note 7, go to IDLE and stay there, buzzer 0, until play_en goes 0→1 or sel_change occurs.
  - In IDLE after completion, a held-high play_en does not restart; a registered play_en edge detect is required.

Test Plan (CLK_FREQ = 1_000_000, BEAT_CYCLES = 4000, GAP_CYCLES = 500):
1. Reset, then play_en = 1, song_sel = 0 → LOAD on the cycle after play_en is sampled; pitch_code = 1; buzzer first rises 1908 cycles after TONE entry; toggles every 1908 cycles; 0 during the last 500 cycles of the slot.
2. song_sel = 1, full song → pitch_code sequence 1,1,5,5,6,6,5,0 with 4000 cycles per slot; note 7 buzzer constantly 0; song_done single pulse at cycle 32000 after the first LOAD.
3. song_sel changes 0→2 mid-note 3 → next cycle LOAD with note_idx = 0, pitch_code = 3 (HP = 1515).
4. play_en dropped during TONE → next cycle IDLE, buzzer = 0, playing = 0, note_idx = 0.
5. End of song with MELODY_LOOP_EN defined → note_idx 7→0, pitch_code returns to the first note. Undefined → IDLE with play_en held 1; toggling play_en 0→1 restarts at note 0.
6. song_sel = 3 → buzzer never toggles over 8 slots; song_done still pulses at cycle 32000.
